hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Producer of the ID/EX enable: decides each cycle whether the decoded instruction
//  enters ID/EX (ena_idex=1) or a bubble is inserted (ena_idex=0, all-zero NOP).
//  Tracks destination registers in flight (no forwarding path exists), stalls
//  PC/IF-ID on RAW hazards, and flushes wrong-path work on a taken branch/jump
//  resolved in EX. Sits beside the decode stage and drives the PC, IF/ID and ID/EX enables.
// PARAMETERS
//  HAZ_DEPTH    3   in-flight stages checked for RAW (EX,MEM,WB); 2 if regfile writes before it is read
//  FLUSH_CYCLES 1   cycles ID/EX is bubbled after a redirect (1..7)
//  CNT_W        32  width of the stall_cycles performance counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  id_valid      in   1      IF/ID holds a real instruction
//  id_rs1        in   5      source register 1 of the ID instruction
//  id_rs2        in   5      source register 2
//  id_rs1_used   in   1      instruction reads rs1
//  id_rs2_used   in   1      instruction reads rs2
//  id_rd         in   5      destination of the ID instruction
//  id_ras_ena    in   1      ID instruction writes id_rd
//  ex_redirect   in   1      taken branch/jump resolved in EX this cycle
//  ena_pc        out  1      PC may update (next-seq or redirect target)
//  ena_ifid      out  1      IF/ID may load
//  flush_ifid    out  1      IF/ID loads a NOP instead of the fetched word
//  ena_idex      out  1      1: ID/EX captures ID; 0: ID/EX loads the all-zero bubble
//  stall_cycles  out  CNT_W  saturating count of RAW-stall cycles
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, scoreboard cleared, flush counter 0, stall_cycles=0;
//   while asserted: ena_pc=0, ena_ifid=0, ena_idex=0, flush_ifid=1.
//  Scoreboard: HAZ_DEPTH entries {wr, rd}; entry 0=EX ... entry HAZ_DEPTH-1=oldest.
//   Each clk shifts by one; entry 0 <= {id_valid&id_ras_ena&(id_rd!=0), id_rd} when
//   ena_idex=1, else {0,0}. Oldest entry drops out.
//  hazard = id_valid & ((id_rs1_used & id_rs1!=0 & match(id_rs1)) | (same for rs2));
//   match(r) = any entry with wr=1 and rd==r. x0 never causes a hazard.
//  FSM (outputs combinational from state + current inputs, zero-cycle decision):
//   RUN/STALL, ex_redirect=1: ena_pc=1, ena_ifid=1, flush_ifid=1, ena_idex=0;
//     load flush counter with FLUSH_CYCLES-1; next = FLUSH if FLUSH_CYCLES>1 else RUN.
//   RUN, hazard=1 (no redirect): ena_pc=0, ena_ifid=0, flush_ifid=0, ena_idex=0;
//     next=STALL; stall_cycles+1.
//   RUN/STALL, no hazard, no redirect: all enables 1, flush_ifid=0; next=RUN.
//   STALL, hazard still 1: same outputs as entering STALL; stall_cycles+1.
//   FLUSH: ena_pc=1, ena_ifid=1, flush_ifid=1, ena_idex=0; counter-1; at 0 -> RUN.
//     ex_redirect in FLUSH (should not occur, EX holds bubbles) reloads the counter.
//  Priority: ex_redirect > hazard (the ID instruction is wrong-path and is discarded).
//  A stall always resolves within HAZ_DEPTH cycles since bubbles shift in.
//  stall_cycles saturates at all-ones; not cleared except by reset.
//  Reset mid-stall/flush: immediately returns to reset outputs; no stale scoreboard.
// TESTING
//  1 Reset held 3 clk -> ena_*=0, flush_ifid=1, stall_cycles=0; release -> all ena=1.
//  2 ID: addi x5 (rd=5,wr) then add rs1=5 next cycle, HAZ_DEPTH=3 -> ena_idex=0 for
//    3 cycles, ena_pc=ena_ifid=0, 4th cycle all 1; stall_cycles=3.
//  3 Producer rd=0 wr=1 then consumer rs1=0 -> no stall, stall_cycles unchanged.
//  4 ex_redirect=1 while hazard=1 -> flush_ifid=1, ena_pc=1, ena_idex=0, no count.
//  5 FLUSH_CYCLES=2, redirect -> ena_idex=0 two cycles, then RUN; rs2_used=0 with
//    rs2 matching in-flight rd -> no stall.
//  6 rst_n low during STALL -> outputs to reset values same cycle; after release no
//    stall for a consumer of the pre-reset rd.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ID/EX enable producer: RAW stalls against in-flight writers, bubbles on EX redirects.
// Zero-cycle combinational decision from state + ID inputs; stalls hold PC and IF/ID.
module hazard_ctrl #(
    parameter int HAZ_DEPTH    = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_ras_ena,
    input  logic             ex_redirect,
    output logic             ena_pc,
    output logic             ena_ifid,
    output logic             flush_ifid,
    output logic             ena_idex,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int             FC_W       = 3;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [FC_W-1:0]            fcnt_q, fcnt_d;
    logic [HAZ_DEPTH-1:0]       sb_wr_q, sb_wr_d;
    logic [HAZ_DEPTH-1:0][4:0]  sb_rd_q, sb_rd_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

    logic rs1_hit, rs2_hit, hazard, count_stall;
    logic ena_pc_c, ena_ifid_c, flush_ifid_c, ena_idex_c;

    always_comb begin : hazard_detect
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_wr_q[i] && (sb_rd_q[i] == id_rs1)) rs1_hit = 1'b1;
            if (sb_wr_q[i] && (sb_rd_q[i] == id_rs2)) rs2_hit = 1'b1;
        end
        hazard = id_valid &
                 ((id_rs1_used & (id_rs1 != 5'd0) & rs1_hit) |
                  (id_rs2_used & (id_rs2 != 5'd0) & rs2_hit));
    end

    always_comb begin : fsm_next
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        count_stall  = 1'b0;
        ena_pc_c     = 1'b1;
        ena_ifid_c   = 1'b1;
        flush_ifid_c = 1'b0;
        ena_idex_c   = 1'b1;

        // Redirect wins over hazard: the ID instruction is wrong-path anyway.
        if (ex_redirect) begin
            flush_ifid_c = 1'b1;
            ena_idex_c   = 1'b0;
            fcnt_d       = FLUSH_LOAD;
            state_d      = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (hazard) begin
                        ena_pc_c    = 1'b0;
                        ena_ifid_c  = 1'b0;
                        ena_idex_c  = 1'b0;
                        count_stall = 1'b1;
                        state_d     = ST_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_ifid_c = 1'b1;
                    ena_idex_c   = 1'b0;
                    fcnt_d       = fcnt_q - FC_W'(1);
                    if (fcnt_q <= FC_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // Reset forces the safe outputs combinationally, so a mid-stall reset acts at once.
    always_comb begin : out_gate
        ena_pc     = ena_pc_c & rst_n;
        ena_ifid   = ena_ifid_c & rst_n;
        ena_idex   = ena_idex_c & rst_n;
        flush_ifid = flush_ifid_c | ~rst_n;
    end

    always_comb begin : sb_shift
        sb_wr_d = '0;
        sb_rd_d = '0;
        for (int i = HAZ_DEPTH - 1; i >= 1; i--) begin
            sb_wr_d[i] = sb_wr_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
        if (ena_idex) begin
            sb_wr_d[0] = id_valid & id_ras_ena & (id_rd != 5'd0);
            sb_rd_d[0] = id_rd;
        end
    end

    always_comb begin : perf_cnt
        stall_cnt_d = stall_cnt_q;
        if (count_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            sb_wr_q     <= '0;
            sb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            sb_wr_q     <= sb_wr_d;
            sb_rd_q     <= sb_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two DUTs (default; FLUSH_CYCLES=2 with 3-bit counter) driven in lockstep, checked by queued expectations.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_ras_ena, ex_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        a_pc, a_ifid, a_fl, a_idex;
    logic [31:0] a_cnt;
    logic        b_pc, b_ifid, b_fl, b_idex;
    logic [2:0]  b_cnt;

    hazard_ctrl u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_ras_ena(id_ras_ena), .ex_redirect(ex_redirect), .ena_pc(a_pc), .ena_ifid(a_ifid),
        .flush_ifid(a_fl), .ena_idex(a_idex), .stall_cycles(a_cnt)
    );

    hazard_ctrl #(.HAZ_DEPTH(3), .FLUSH_CYCLES(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_ras_ena(id_ras_ena), .ex_redirect(ex_redirect), .ena_pc(b_pc), .ena_ifid(b_ifid),
        .flush_ifid(b_fl), .ena_idex(b_idex), .stall_cycles(b_cnt)
    );

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        fl;
        logic        idex;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit done   = 0;

    // Reference model: per register, the last cycle in which an accepted writer is still in flight.
    int          busy_until [2][32];
    int          flush_rem  [2];
    logic [31:0] cnt_m      [2];
    int          cyc = 0;
    localparam int HD = 3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset(input int i);
        for (int r = 0; r < 32; r++) busy_until[i][r] = -1;
        flush_rem[i] = 0;
        cnt_m[i]     = 0;
    endtask

    task automatic model_step(input int i, output exp_t e);
        int          fc;
        logic [31:0] cmax;
        bit          haz, pass;
        fc   = (i == 0) ? 1 : 2;
        cmax = (i == 0) ? 32'hFFFF_FFFF : 32'd7;
        if (!rst_n) begin
            model_reset(i);
            e = '{pc: 1'b0, ifid: 1'b0, fl: 1'b1, idex: 1'b0, cnt: 32'd0};
            return;
        end
        haz = id_valid &&
              ((id_rs1_used && id_rs1 != 0 && busy_until[i][id_rs1] >= cyc) ||
               (id_rs2_used && id_rs2 != 0 && busy_until[i][id_rs2] >= cyc));
        e.cnt = cnt_m[i];
        pass  = 1'b0;
        if (ex_redirect) begin
            e.pc = 1; e.ifid = 1; e.fl = 1; e.idex = 0;
            flush_rem[i] = fc - 1;
        end else if (flush_rem[i] > 0) begin
            e.pc = 1; e.ifid = 1; e.fl = 1; e.idex = 0;
            flush_rem[i]--;
        end else if (haz) begin
            e.pc = 0; e.ifid = 0; e.fl = 0; e.idex = 0;
            if (cnt_m[i] != cmax) cnt_m[i]++;
        end else begin
            e.pc = 1; e.ifid = 1; e.fl = 0; e.idex = 1;
            pass = 1'b1;
        end
        if (pass && id_valid && id_ras_ena && id_rd != 0)
            busy_until[i][id_rd] = cyc + HD;
    endtask

    task automatic step(input bit r, input bit v, input logic [4:0] s1, input bit u1,
                        input logic [4:0] s2, input bit u2, input logic [4:0] rd,
                        input bit wr, input bit red);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = r; id_valid = v; id_rs1 = s1; id_rs1_used = u1; id_rs2 = s2;
        id_rs2_used = u2; id_rd = rd; id_ras_ena = wr; ex_redirect = red;
        model_step(0, e); q0.push_back(e);
        model_step(1, e); q1.push_back(e);
    endtask

    task automatic nop();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string nm, input int d, input exp_t got, input exp_t want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got pc=%b ifid=%b flush=%b idex=%b cnt=%0d, want pc=%b ifid=%b flush=%b idex=%b cnt=%0d",
                      nm, d, got.pc, got.ifid, got.fl, got.idex, got.cnt,
                      want.pc, want.ifid, want.fl, want.idex, want.cnt);
    endtask

    initial begin : monitor
        exp_t g, w;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            g = '{pc: a_pc, ifid: a_ifid, fl: a_fl, idex: a_idex, cnt: a_cnt};
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL q0_underflow at cycle %0d: got empty queue, want entry", cyc);
            end else begin
                w = q0.pop_front();
                cmp("outputs", 1, g, w);
            end
            g = '{pc: b_pc, ifid: b_ifid, fl: b_fl, idex: b_idex, cnt: {29'd0, b_cnt}};
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL q1_underflow at cycle %0d: got empty queue, want entry", cyc);
            end else begin
                w = q1.pop_front();
                cmp("outputs", 2, g, w);
            end
        end
    end

    initial begin : driver
        rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_ras_ena = 0; ex_redirect = 0;
        model_reset(0);
        model_reset(1);

        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();

        // addi x5 then add x?, x5: three stall cycles, released on the fourth
        step(1, 1, 0, 0, 0, 0, 5, 1, 0);
        repeat (4) step(1, 1, 5, 1, 0, 0, 9, 1, 0);
        @(negedge clk);
        #1;
        n_chk++;
        if (a_cnt === 32'd3) n_pass++;
        else $display("FAIL stall_count_raw: got %0d, want 3", a_cnt);
        repeat (3) nop();

        // x0 writer never blocks an x0 reader
        step(1, 1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 1, 4, 1, 0);
        repeat (3) nop();

        // redirect on top of a live hazard
        step(1, 1, 0, 0, 0, 0, 7, 1, 0);
        step(1, 1, 7, 1, 0, 0, 8, 1, 1);
        repeat (4) nop();

        // plain redirect, then an unused rs2 matching an in-flight rd
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) nop();
        step(1, 1, 0, 0, 0, 0, 9, 1, 0);
        step(1, 1, 1, 0, 9, 0, 3, 1, 0);
        repeat (3) nop();

        // reset in the middle of a stall, consumer held across it
        step(1, 1, 0, 0, 0, 0, 6, 1, 0);
        step(1, 1, 6, 1, 0, 0, 2, 1, 0);
        step(0, 1, 6, 1, 0, 0, 2, 1, 0);
        step(0, 1, 6, 1, 0, 0, 2, 1, 0);
        step(1, 1, 6, 1, 0, 0, 2, 1, 0);
        repeat (2) nop();

        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 249) != 0,
                 $urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        #1;
        done = 1;
        n_chk++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d/%0d left, want 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
